// File: rtl/srs_cs_detect.sv
// SRS cyclic-shift detector: bins delay-profile power per cyclic shift, then searches
// every base shift summed over the active ports. Optional threshold flag under SRS_CS_DET_THR_EN.
module srs_cs_detect #(
  parameter int PWR_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ktc,
  input  logic [1:0]       ap_num,
  input  logic [7:0]       bin_len,
  input  logic             in_vld,
  input  logic [PWR_W-1:0] in_pwr,
  output logic             in_rdy,
  output logic             busy,
  output logic             det_vld,
  output logic [3:0]       det_cs,
  output logic [3:0]       det_a1,
  output logic [3:0]       det_a2,
  output logic [3:0]       det_a3,
  output logic [ACC_W+1:0] det_energy
`ifdef SRS_CS_DET_THR_EN
  ,
  input  logic [ACC_W+1:0] det_thr,
  output logic             det_ok
`endif
);

  localparam int HW = ACC_W + 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_ACC = 2'd1, S_SRCH = 2'd2, S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ktc_q, ktc_d;
  logic [1:0]    lnp_q, lnp_d;
  logic [7:0]    blen_q, blen_d;
  logic [3:0]    bin_q, bin_d;
  logic [7:0]    scnt_q, scnt_d;
  logic [3:0]    c_q, c_d;
  logic [1:0]    k_q, k_d;
  logic [HW-1:0] hyp_q, hyp_d, best_q, best_d;
  logic [3:0]    best_cs_q, best_cs_d;
  logic [ACC_W-1:0] acc_q [12];
  logic [ACC_W-1:0] acc_d [12];
  logic          det_vld_q, det_vld_d;
  logic [3:0]    det_cs_q, det_cs_d, det_a1_q, det_a1_d, det_a2_q, det_a2_d, det_a3_q, det_a3_d;
  logic [HW-1:0] det_energy_q, det_energy_d;
`ifdef SRS_CS_DET_THR_EN
  logic          det_ok_q, det_ok_d;
`endif

  logic [3:0]    cs_max, step, np_m1, kstep, sel_bin, sh1, sh2, sh3;
  logic [HW-1:0] hyp_sum;

  function automatic logic [3:0] mod_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] m);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[3:0];
  endfunction

  // Bin b holds cs = (cs_max - b) mod cs_max, so the inverse mapping is the same expression.
  function automatic logic [3:0] bin_of(input logic [3:0] cs, input logic [3:0] m);
    return (cs == 4'd0) ? 4'd0 : m - cs;
  endfunction

  assign cs_max  = ktc_q ? 4'd12 : 4'd8;
  assign step    = cs_max >> lnp_q;
  assign np_m1   = (lnp_q == 2'd2) ? 4'd3 : (lnp_q == 2'd1) ? 4'd1 : 4'd0;
  assign kstep   = {2'b00, k_q} * step;
  assign sel_bin = bin_of(mod_add(c_q, kstep, cs_max), cs_max);
  assign hyp_sum = hyp_q + HW'(acc_q[sel_bin]);
  assign sh1     = mod_add(best_cs_q, step, cs_max);
  assign sh2     = mod_add(sh1, step, cs_max);
  assign sh3     = mod_add(sh2, step, cs_max);

  always_comb begin
    state_d      = state_q;
    ktc_d        = ktc_q;
    lnp_d        = lnp_q;
    blen_d       = blen_q;
    bin_d        = bin_q;
    scnt_d       = scnt_q;
    c_d          = c_q;
    k_d          = k_q;
    hyp_d        = hyp_q;
    best_d       = best_q;
    best_cs_d    = best_cs_q;
    acc_d        = acc_q;
    det_vld_d    = 1'b0;
    det_cs_d     = det_cs_q;
    det_a1_d     = det_a1_q;
    det_a2_d     = det_a2_q;
    det_a3_d     = det_a3_q;
    det_energy_d = det_energy_q;
`ifdef SRS_CS_DET_THR_EN
    det_ok_d     = det_ok_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ktc_d     = ktc;
          lnp_d     = (ap_num == 2'b11) ? 2'd2 : (ap_num == 2'b01) ? 2'd1 : 2'd0;
          blen_d    = (bin_len == 8'd0) ? 8'd1 : bin_len;
          for (int i = 0; i < 12; i++) acc_d[i] = '0;
          best_d    = '0;
          best_cs_d = '0;
          hyp_d     = '0;
          bin_d     = '0;
          scnt_d    = '0;
          c_d       = '0;
          k_d       = '0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        if (in_vld) begin
          acc_d[bin_q] = acc_q[bin_q] + ACC_W'(in_pwr);
          if (scnt_q == blen_q - 8'd1) begin
            scnt_d = '0;
            if (bin_q == cs_max - 4'd1) state_d = S_SRCH;
            else bin_d = bin_q + 4'd1;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
      end
      S_SRCH: begin
        if ({2'b00, k_q} == np_m1) begin
          hyp_d = '0;
          k_d   = '0;
          if (hyp_sum > best_q) begin
            best_d    = hyp_sum;
            best_cs_d = c_q;
          end
          if (c_q == cs_max - 4'd1) state_d = S_DONE;
          else c_d = c_q + 4'd1;
        end else begin
          hyp_d = hyp_sum;
          k_d   = k_q + 2'd1;
        end
      end
      default: begin
        det_vld_d    = 1'b1;
        det_cs_d     = best_cs_q;
        det_a1_d     = (lnp_q != 2'd0) ? sh1 : 4'd0;
        det_a2_d     = (lnp_q == 2'd2) ? sh2 : 4'd0;
        det_a3_d     = (lnp_q == 2'd2) ? sh3 : 4'd0;
        det_energy_d = best_q;
`ifdef SRS_CS_DET_THR_EN
        det_ok_d     = best_q > det_thr;
`endif
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ktc_q        <= 1'b0;
      lnp_q        <= '0;
      blen_q       <= 8'd1;
      bin_q        <= '0;
      scnt_q       <= '0;
      c_q          <= '0;
      k_q          <= '0;
      hyp_q        <= '0;
      best_q       <= '0;
      best_cs_q    <= '0;
      for (int i = 0; i < 12; i++) acc_q[i] <= '0;
      det_vld_q    <= 1'b0;
      det_cs_q     <= '0;
      det_a1_q     <= '0;
      det_a2_q     <= '0;
      det_a3_q     <= '0;
      det_energy_q <= '0;
`ifdef SRS_CS_DET_THR_EN
      det_ok_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ktc_q        <= ktc_d;
      lnp_q        <= lnp_d;
      blen_q       <= blen_d;
      bin_q        <= bin_d;
      scnt_q       <= scnt_d;
      c_q          <= c_d;
      k_q          <= k_d;
      hyp_q        <= hyp_d;
      best_q       <= best_d;
      best_cs_q    <= best_cs_d;
      acc_q        <= acc_d;
      det_vld_q    <= det_vld_d;
      det_cs_q     <= det_cs_d;
      det_a1_q     <= det_a1_d;
      det_a2_q     <= det_a2_d;
      det_a3_q     <= det_a3_d;
      det_energy_q <= det_energy_d;
`ifdef SRS_CS_DET_THR_EN
      det_ok_q     <= det_ok_d;
`endif
    end
  end

  assign in_rdy     = (state_q == S_ACC);
  assign busy       = (state_q != S_IDLE);
  assign det_vld    = det_vld_q;
  assign det_cs     = det_cs_q;
  assign det_a1     = det_a1_q;
  assign det_a2     = det_a2_q;
  assign det_a3     = det_a3_q;
  assign det_energy = det_energy_q;
`ifdef SRS_CS_DET_THR_EN
  assign det_ok     = det_ok_q;
`endif

endmodule

// File: doc/srs_cs_detect.md
Name: srs_cs_detect

Overview:
- Receiver-side counterpart of the UE SRS cyclic-shift generator.
- Consumes the per-sample power of the time-domain delay profile for one SRS comb/symbol. This is the output of the LS correlation and IFFT in the gNB SRS chain.
- Accumulates energy per cyclic-shift bin, then searches all base cyclic-shift hypotheses, each summed over the configured antenna ports.
- Reports the detected srs_cs (a0) plus the per-port shifts a1..a3 to the SRS channel-estimation stage.

Parameters:
- PWR_W, 16, width of the unsigned input power sample.
- ACC_W, 24, width of the per-bin accumulator; must be at least PWR_W+8.

Ports:
- clk  input  1  block clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; latches the configuration and begins a detection. Honoured only in IDLE.
- ktc  input  1  0: cs_max=8; 1: cs_max=12.
- ap_num  input  2  00: 1 port, 01: 2 ports, 11: 4 ports; 10 is treated as 1 port.
- bin_len  input  8  samples per cyclic-shift bin; 0 is treated as 1.
- in_vld  input  1  power sample valid.
- in_pwr  input  PWR_W  unsigned power sample.
- in_rdy  output  1  sample accepted when in_vld and in_rdy are both high.
- busy  output  1  high in every state except IDLE.
- det_vld  output  1  one-cycle result strobe.
- det_cs  output  4  detected base cyclic shift (a0).
- det_a1, det_a2, det_a3  output  4 each  per-port shifts; unused ports are 0.
- det_energy  output  ACC_W+2  summed energy of the winning hypothesis.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulators cleared.
- FSM states: IDLE, ACC, SRCH, DONE.
- IDLE:
  - in_rdy=0.
  - On start: latch ktc, ap_num and bin_len; clear all 12 accumulators, the best-energy register and best_cs; go to ACC.
- ACC:
  - in_rdy=1.
  - Each accepted sample adds to acc[bin], where bin counts 0..cs_max-1 and advances after every bin_len accepted samples.
  - Total accepted samples = cs_max*bin_len. The cycle the last sample is accepted, go to SRCH.
  - Stalls (in_vld=0) are allowed with no time limit.
- Bin mapping: bin b holds the energy of cs = (cs_max - b) mod cs_max. Example: bin 0 is cs 0, bin 1 is cs cs_max-1.
- SRCH:
  - in_rdy=0. Candidate c runs 0..cs_max-1; port k runs 0..np-1, where np = 1, 2 or 4.
  - step = cs_max/np.
  - Each cycle adds acc[(cs_max - ((c + k*step) mod cs_max)) mod cs_max] into the hypothesis sum.
  - After port np-1, compare the hypothesis sum with best. Update only if strictly greater, so a tie keeps the lower c.
  - SRCH lasts exactly cs_max*np cycles, then go to DONE.
- DONE:
  - det_vld=1 for one cycle. det_cs, det_a1..det_a3 and det_energy are updated on this cycle and held until the next DONE.
  - Port shifts:
    - a1 = (c + step) mod cs_max when np >= 2, else 0.
    - a2 = (c + 2*step) mod cs_max when np = 4, else 0.
    - a3 = (c + 3*step) mod cs_max when np = 4, else 0.
  - Next state is IDLE.
- Latency: from the last accepted sample to det_vld is cs_max*np+1 cycles.
- Accumulator width rules:
  - Accumulators wrap modulo 2^ACC_W; with the defaults no overflow is possible.
  - Hypothesis sum and best are ACC_W+2 bits.
- Boundary conditions:
  - All-zero input: det_cs=0, det_energy=0.
  - start while busy is ignored; the latched configuration does not change mid-operation.
  - rst asserted in any state returns to IDLE immediately; partial accumulations are discarded.

Optional Feature:
- Macro SRS_CS_DET_THR_EN.
- When defined:
  - Adds input det_thr (ACC_W+2 bits) and output det_ok (1 bit).
  - det_ok is registered with det_vld: 1 if det_energy > det_thr, else 0. det_ok resets to 0.
  - det_thr is sampled in DONE.
- When undefined: neither port exists, and the search path is unchanged.

Test Plan:
- ktc=0, ap_num=00, bin_len=4; all samples 1 except bin 3 samples = 100 → det_cs=5, a1..a3=0, det_energy=400, det_vld 9 cycles after the last sample.
- ktc=1, ap_num=11, bin_len=2; energy only in the bins for cs 2, 5, 8, 11, samples = 50 → det_cs=2, a1=5, a2=8, a3=11, det_energy=400, det_vld 49 cycles after the last sample.
- ktc=0, ap_num=01, bin_len=1; bins for cs 1 and 5 = 10 each, bins for cs 3 and 7 = 10 each → tie; det_cs=1, a1=5.
- in_vld toggled randomly during ACC; pulse start mid-ACC → same result as the gap-free run; start is ignored.
- rst pulsed mid-SRCH → all outputs 0 and IDLE. A subsequent clean run produces the correct result with no residue from earlier accumulations.
- With SRS_CS_DET_THR_EN and the first scenario: det_thr=399 → det_ok=1; det_thr=400 → det_ok=0.
